// File: rtl/mux_select_debouncer.sv
// mux_select_debouncer: turns a bouncy push-button into a clean, registered
// 2:1 mux select. Every debounced press toggles selection_input. The block also
// produces a one-cycle change strobe and the debounced button level.
module mux_select_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned CNT_WIDTH       = 18,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned BTN_ACTIVE_HIGH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic selection_input,
  output logic sel_changed,
  output logic btn_level
);

  // Pin level of btn_raw while the button is released. The synchroniser resets
  // to this level so that leaving reset never looks like a press.
  localparam logic RELEASED_LVL = (BTN_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RELEASED        = 2'd0,
    S_CONFIRM_PRESS   = 2'd1,
    S_PRESSED         = 2'd2,
    S_CONFIRM_RELEASE = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_btn_sync;
  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_sel;
  logic                   r_changed;
  logic                   r_level;

  // Bring the asynchronous pin into the clock domain through a flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RELEASED_LVL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign w_btn_sync = (BTN_ACTIVE_HIGH != 0) ? r_sync[SYNC_STAGES-1]
                                             : ~r_sync[SYNC_STAGES-1];

  // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive stable samples. Outputs are updated on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RELEASED;
      r_cnt     <= '0;
      r_sel     <= 1'b0;
      r_changed <= 1'b0;
      r_level   <= 1'b0;
    end else begin
      r_changed <= 1'b0;
      case (r_state)
        S_RELEASED: begin
          if (w_btn_sync) begin
            r_state <= S_CONFIRM_PRESS;
            r_cnt   <= CNT_WIDTH'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        S_CONFIRM_PRESS: begin
          if (!w_btn_sync) begin
            r_state <= S_RELEASED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= S_PRESSED;
            r_cnt     <= '0;
            r_sel     <= ~r_sel;
            r_changed <= 1'b1;
            r_level   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end
        S_PRESSED: begin
          if (!w_btn_sync) begin
            r_state <= S_CONFIRM_RELEASE;
            r_cnt   <= CNT_WIDTH'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        S_CONFIRM_RELEASE: begin
          if (w_btn_sync) begin
            r_state <= S_PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_RELEASED;
            r_cnt   <= '0;
            r_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          r_state <= S_RELEASED;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign selection_input = r_sel;
  assign sel_changed     = r_changed;
  assign btn_level       = r_level;

endmodule

// File: tb/tb_mux_select_debouncer.sv
// Directed bench for mux_select_debouncer with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// An active-high instance covers the main behaviour. An active-low instance
// covers button polarity.
module tb_mux_select_debouncer;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_raw;
  logic btn_raw_n;
  logic sel, chg, lvl;
  logic sel_n, chg_n, lvl_n;

  int   n_pass   = 0;
  int   n_checks = 0;
  int   pulses   = 0;
  logic lvl_seen = 1'b0;

  always #5 clk = ~clk;

  mux_select_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH(3),
    .SYNC_STAGES(2),
    .BTN_ACTIVE_HIGH(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .selection_input(sel),
    .sel_changed(chg),
    .btn_level(lvl)
  );

  mux_select_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH(3),
    .SYNC_STAGES(2),
    .BTN_ACTIVE_HIGH(0)
  ) dut_n (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw_n),
    .selection_input(sel_n),
    .sel_changed(chg_n),
    .btn_level(lvl_n)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance n falling edges, recording strobes and the level of the active-high instance.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (chg === 1'b1) pulses++;
      if (lvl === 1'b1) lvl_seen = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: reset with a toggling button
    rst_n     = 1'b0;
    btn_raw   = 1'b0;
    btn_raw_n = 1'b1;
    #1;
    chk("rst_sel_t0", sel, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      btn_raw   = ~btn_raw;
      btn_raw_n = ~btn_raw_n;
    end
    @(negedge clk);
    chk("rst_sel", sel, 1'b0);
    chk("rst_chg", chg, 1'b0);
    chk("rst_lvl", lvl, 1'b0);
    chk("rst_sel_n", sel_n, 1'b0);
    chk("rst_lvl_n", lvl_n, 1'b0);
    btn_raw   = 1'b0;
    btn_raw_n = 1'b1;
    rst_n     = 1'b1;
    pulses    = 0;
    lvl_seen  = 1'b0;
    tick(20);
    chk("idle_sel", sel, 1'b0);
    chk("idle_lvl_seen", lvl_seen, 1'b0);
    chk_int("idle_pulses", pulses, 0);
    chk("idle_sel_n", sel_n, 1'b0);

    // Test 2: clean press held for 20 cycles
    btn_raw = 1'b1;
    tick(5);
    chk("press_sel_early", sel, 1'b0);
    chk("press_lvl_early", lvl, 1'b0);
    tick(1);
    chk("press_sel", sel, 1'b1);
    chk("press_chg", chg, 1'b1);
    chk("press_lvl", lvl, 1'b1);
    tick(1);
    chk("press_chg_drop", chg, 1'b0);
    tick(13);
    chk_int("press_hold_pulses", pulses, 1);
    chk("press_hold_sel", sel, 1'b1);
    btn_raw = 1'b0;
    tick(10);
    chk("release_lvl", lvl, 1'b0);
    chk("release_sel", sel, 1'b1);

    // Test 3: bounce shorter than the debounce window
    pulses   = 0;
    lvl_seen = 1'b0;
    btn_raw = 1'b1; tick(3);
    btn_raw = 1'b0; tick(1);
    btn_raw = 1'b1; tick(3);
    btn_raw = 1'b0; tick(10);
    chk("bounce_sel", sel, 1'b1);
    chk_int("bounce_pulses", pulses, 0);
    chk("bounce_lvl_seen", lvl_seen, 1'b0);

    // Test 4: two presses starting from a freshly reset select
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk("two_start_sel", sel, 1'b0);
    pulses  = 0;
    btn_raw = 1'b1;
    tick(10);
    chk("two_first_sel", sel, 1'b1);
    btn_raw = 1'b0;
    tick(5);
    chk("two_lvl_before_fall", lvl, 1'b1);
    tick(1);
    chk("two_lvl_fall", lvl, 1'b0);
    tick(4);
    btn_raw = 1'b1;
    tick(10);
    chk("two_second_sel", sel, 1'b0);
    chk("two_second_lvl", lvl, 1'b1);
    chk_int("two_pulses", pulses, 2);

    // Bring select to 1 with the button released before the mid-confirm reset
    btn_raw = 1'b0; tick(10);
    btn_raw = 1'b1; tick(10);
    btn_raw = 1'b0; tick(10);
    chk("pre5_sel", sel, 1'b1);
    chk("pre5_lvl", lvl, 1'b0);

    // Test 5: reset during CONFIRM_PRESS with the button held
    btn_raw = 1'b1;
    tick(4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_sel", sel, 1'b0);
    chk("midrst_chg", chg, 1'b0);
    chk("midrst_lvl", lvl, 1'b0);
    tick(2);
    rst_n  = 1'b1;
    pulses = 0;
    tick(5);
    chk("midrst_sel_early", sel, 1'b0);
    tick(1);
    chk("midrst_sel_toggle", sel, 1'b1);
    chk("midrst_chg_toggle", chg, 1'b1);
    tick(10);
    chk_int("midrst_pulses", pulses, 1);

    // Test 6: active-low button polarity
    chk("pol_start_sel", sel_n, 1'b0);
    btn_raw_n = 1'b0;
    tick(10);
    chk("pol_press_sel", sel_n, 1'b1);
    chk("pol_press_lvl", lvl_n, 1'b1);
    btn_raw_n = 1'b1;
    tick(10);
    chk("pol_release_lvl", lvl_n, 1'b0);
    chk("pol_release_sel", sel_n, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
